// File: rtl/phy_write_sequencer_pkg.sv
// Shared PHY write-path types: sequencer FSM states and timing constants.
// PHY_WR_PREAMBLE_EN selects how far ahead an IDLE launch has to be decided.
package phy_write_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2
    } wr_state_t;

    localparam int DEFAULT_BURST_LENGTH = 8;
    localparam int MIN_CWL              = 2;

    // Cycles before the first beat at which a launch from IDLE is taken.
`ifdef PHY_WR_PREAMBLE_EN
    localparam int IDLE_LAUNCH_LEAD = 2;
`else
    localparam int IDLE_LAUNCH_LEAD = 1;
`endif

endpackage

// File: rtl/phy_wr_cwl_queue.sv
// In-order queue of accepted WRITE commands, each holding a countdown to its first data beat.
// All occupied counters tick down together; only the head is examined for launch.
module phy_wr_cwl_queue
    import phy_write_sequencer_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter int  CWL_WIDTH = 6,
    parameter int  LEAD      = 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk2x,
    input  logic                 rst,
    input  logic                 push,
    input  logic [CWL_WIDTH-1:0] cwl,
    input  logic                 pop,
    output logic [CNT_W-1:0]     count,
    output logic                 head_due,
    output logic                 head_due_next,
    output logic                 head_lead
);

    logic [CWL_WIDTH-1:0] slot_cnt [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CWL_WIDTH-1:0] load_val;
    logic [CWL_WIDTH-1:0] head_cnt;
    logic                 head_valid;

    // Counter = cycles until the first beat; the accept cycle already counts as one.
    assign load_val = (cwl > CWL_WIDTH'(MIN_CWL)) ? cwl - CWL_WIDTH'(1)
                                                  : CWL_WIDTH'(MIN_CWL - 1);

    assign head_valid    = (count != '0);
    assign head_cnt      = slot_cnt[rd_ptr];
    assign head_due      = head_valid && (head_cnt == '0);
    assign head_due_next = head_valid && (head_cnt == CWL_WIDTH'(1));
    assign head_lead     = head_valid && (head_cnt == CWL_WIDTH'(LEAD));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk2x or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_cnt[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_cnt[i] != '0) begin
                    slot_cnt[i] <= slot_cnt[i] - CWL_WIDTH'(1);
                end
            end
            if (push) begin
                slot_cnt[wr_ptr] <= load_val;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/phy_write_sequencer.sv
// Turns WRITE command issue into a data-drive window tCWL later, chaining bursts back to back.
// PHY_WR_PREAMBLE_EN inserts a DQS preamble cycle ahead of bursts launched from IDLE.
module phy_write_sequencer
    import phy_write_sequencer_pkg::*;
#(
    parameter int  BURST_LENGTH = DEFAULT_BURST_LENGTH,
    parameter int  MAX_PENDING  = 4,
    parameter int  CWL_WIDTH    = 6,
    localparam int CNT_W        = $clog2(MAX_PENDING) + 1
) (
    input  logic                 clk2x,
    input  logic                 rst,
    input  logic                 wr_cmd_valid,
    output logic                 wr_cmd_ready,
    input  logic [CWL_WIDTH-1:0] cwl_cycles,
    output logic                 drive_en,
    output logic                 preamble,
    output logic                 burst_done,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 busy,
    output logic                 err_overlap
);

    localparam int BEAT_W = $clog2(BURST_LENGTH);

    wr_state_t         state;
    logic [BEAT_W-1:0] beat;
    logic              accept;
    logic              launch;
    logic              launch_idle;
    logic              last_beat;
    logic              late;
    logic              err_set;
    logic              head_due;
    logic              head_due_next;
    logic              head_lead;

    assign wr_cmd_ready = (pending_cnt < CNT_W'(MAX_PENDING));
    assign accept       = wr_cmd_valid && wr_cmd_ready;
    assign last_beat    = (state == BURST) && (beat == BEAT_W'(BURST_LENGTH - 1));
    assign launch_idle  = (state == IDLE) && (head_lead || head_due_next || head_due);
    assign launch       = launch_idle || (last_beat && (head_due_next || head_due));

    // A launch is late when the head has already passed the point it should have gone at.
    assign late    = launch && (launch_idle ? !head_lead : head_due);
    assign err_set = late
                  || (wr_cmd_valid && !wr_cmd_ready)
                  || ((state == BURST) && !last_beat && head_due);
    assign busy    = (pending_cnt != '0) || (state != IDLE);

    phy_wr_cwl_queue #(
        .DEPTH     (MAX_PENDING),
        .CWL_WIDTH (CWL_WIDTH),
        .LEAD      (IDLE_LAUNCH_LEAD)
    ) u_queue (
        .clk2x         (clk2x),
        .rst           (rst),
        .push          (accept),
        .cwl           (cwl_cycles),
        .pop           (launch),
        .count         (pending_cnt),
        .head_due      (head_due),
        .head_due_next (head_due_next),
        .head_lead     (head_lead)
    );

`ifdef PHY_WR_PREAMBLE_EN
    logic pre_q;
    assign preamble = pre_q;
`else
    assign preamble = 1'b0;
`endif

    always_ff @(posedge clk2x or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            drive_en    <= 1'b0;
            burst_done  <= 1'b0;
            err_overlap <= 1'b0;
`ifdef PHY_WR_PREAMBLE_EN
            pre_q       <= 1'b0;
`endif
        end else begin
            if (err_set) begin
                err_overlap <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (launch) begin
`ifdef PHY_WR_PREAMBLE_EN
                        state <= PRE;
                        pre_q <= 1'b1;
`else
                        state    <= BURST;
                        beat     <= '0;
                        drive_en <= 1'b1;
`endif
                    end
                end
                PRE: begin
                    state    <= BURST;
                    beat     <= '0;
                    drive_en <= 1'b1;
`ifdef PHY_WR_PREAMBLE_EN
                    pre_q    <= 1'b0;
`endif
                end
                BURST: begin
                    if (last_beat) begin
                        beat       <= '0;
                        burst_done <= 1'b0;
                        if (!launch) begin
                            state    <= IDLE;
                            drive_en <= 1'b0;
                        end
                    end else begin
                        beat       <= beat + BEAT_W'(1);
                        burst_done <= (beat == BEAT_W'(BURST_LENGTH - 2));
                    end
                end
                default: begin
                    state      <= IDLE;
                    drive_en   <= 1'b0;
                    burst_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_write_sequencer.sv
// Directed bench for phy_write_sequencer: cycle-indexed output traces against hand-computed masks.
// Expectations that differ when PHY_WR_PREAMBLE_EN is defined are selected by the same macro.
module tb_phy_write_sequencer;

    logic       clk2x        = 1'b0;
    logic       rst          = 1'b1;
    logic       wr_cmd_valid = 1'b0;
    logic [5:0] cwl_cycles   = 6'd0;
    logic       wr_cmd_ready;
    logic       drive_en;
    logic       preamble;
    logic       burst_done;
    logic [2:0] pending_cnt;
    logic       busy;
    logic       err_overlap;

    int checks   = 0;
    int failures = 0;

    logic [63:0] o_drive;
    logic [63:0] o_done;
    logic [63:0] o_busy;
    logic [63:0] o_err;
    logic [63:0] o_ready;
    logic [63:0] o_pre;
    logic [2:0]  o_pend [64];

    phy_write_sequencer dut (
        .clk2x        (clk2x),
        .rst          (rst),
        .wr_cmd_valid (wr_cmd_valid),
        .wr_cmd_ready (wr_cmd_ready),
        .cwl_cycles   (cwl_cycles),
        .drive_en     (drive_en),
        .preamble     (preamble),
        .burst_done   (burst_done),
        .pending_cnt  (pending_cnt),
        .busy         (busy),
        .err_overlap  (err_overlap)
    );

    always #5 clk2x = ~clk2x;

    task automatic do_reset();
        @(negedge clk2x);
        rst          = 1'b0;
        wr_cmd_valid = 1'b0;
        repeat (2) @(negedge clk2x);
        rst = 1'b1;
    endtask

    // Cycle k is sampled mid-cycle; a command in cmds[k] is accepted at the edge ending cycle k.
    task automatic run(input logic [63:0] cmds, input logic [5:0] cwl, input int ncyc);
        o_drive = '0; o_done = '0; o_busy = '0; o_err = '0; o_ready = '0; o_pre = '0;
        for (int k = 0; k < 64; k++) o_pend[k] = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk2x);
            o_drive[k] = drive_en;
            o_done[k]  = burst_done;
            o_busy[k]  = busy;
            o_err[k]   = err_overlap;
            o_ready[k] = wr_cmd_ready;
            o_pre[k]   = preamble;
            o_pend[k]  = pending_cnt;
            wr_cmd_valid = cmds[k];
            cwl_cycles   = cwl;
        end
        @(negedge clk2x);
        wr_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        wr_cmd_valid = 1'b0;
        cwl_cycles   = 6'd10;
        repeat (2) @(negedge clk2x);
        checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL reset_drive_en got=%b exp=0", drive_en); end
        checks++; if (preamble !== 1'b0) begin failures++; $display("FAIL reset_preamble got=%b exp=0", preamble); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL reset_burst_done got=%b exp=0", burst_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_overlap !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overlap); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        checks++; if (wr_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_cmd_ready); end
        rst          = 1'b1;
        wr_cmd_valid = 1'b1;
        @(negedge clk2x);
        wr_cmd_valid = 1'b0;
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL first_accept_pending got=%0d exp=1", pending_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_accept_busy got=%b exp=1", busy); end
    endtask

    task automatic test_single();
        logic [63:0] exp_pre;
`ifdef PHY_WR_PREAMBLE_EN
        exp_pre = 64'h200;
`else
        exp_pre = 64'h0;
`endif
        do_reset();
        run(64'h1, 6'd10, 30);
        checks++; if (o_drive !== 64'h3FC00) begin failures++; $display("FAIL single_drive got=%h exp=%h", o_drive, 64'h3FC00); end
        checks++; if (o_done !== 64'h20000) begin failures++; $display("FAIL single_done got=%h exp=%h", o_done, 64'h20000); end
        checks++; if (o_busy !== 64'h3FFFE) begin failures++; $display("FAIL single_busy got=%h exp=%h", o_busy, 64'h3FFFE); end
        checks++; if (o_pre !== exp_pre) begin failures++; $display("FAIL single_preamble got=%h exp=%h", o_pre, exp_pre); end
        checks++; if (o_err !== 64'h0) begin failures++; $display("FAIL single_err got=%h exp=0", o_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run(64'h101, 6'd10, 30);
        checks++; if (o_drive !== 64'h3FFFC00) begin failures++; $display("FAIL b2b_drive got=%h exp=%h", o_drive, 64'h3FFFC00); end
        checks++; if (o_done !== 64'h2020000) begin failures++; $display("FAIL b2b_done got=%h exp=%h", o_done, 64'h2020000); end
        checks++; if (o_err !== 64'h0) begin failures++; $display("FAIL b2b_err got=%h exp=0", o_err); end
        checks++; if (o_pend[9] !== 3'd2) begin failures++; $display("FAIL b2b_pending9 got=%0d exp=2", o_pend[9]); end
        checks++; if (o_pend[12] !== 3'd1) begin failures++; $display("FAIL b2b_pending12 got=%0d exp=1", o_pend[12]); end
    endtask

    task automatic test_overlap();
        do_reset();
        run(64'h11, 6'd10, 30);
        checks++; if (o_drive !== 64'h3FFFC00) begin failures++; $display("FAIL overlap_drive got=%h exp=%h", o_drive, 64'h3FFFC00); end
        checks++; if (o_done !== 64'h2020000) begin failures++; $display("FAIL overlap_done got=%h exp=%h", o_done, 64'h2020000); end
        checks++; if (o_err !== 64'h3FFF8000) begin failures++; $display("FAIL overlap_err got=%h exp=%h", o_err, 64'h3FFF8000); end
        checks++; if (o_busy !== 64'h3FFFFFE) begin failures++; $display("FAIL overlap_busy got=%h exp=%h", o_busy, 64'h3FFFFFE); end
        checks++; if (o_pend[12] !== 3'd1) begin failures++; $display("FAIL overlap_pending12 got=%0d exp=1", o_pend[12]); end
    endtask

    task automatic test_full();
        do_reset();
        run(64'h1F, 6'd40, 12);
        checks++; if (o_ready !== 64'hF) begin failures++; $display("FAIL full_ready got=%h exp=%h", o_ready, 64'hF); end
        checks++; if (o_pend[4] !== 3'd4) begin failures++; $display("FAIL full_pending4 got=%0d exp=4", o_pend[4]); end
        checks++; if (o_pend[11] !== 3'd4) begin failures++; $display("FAIL full_pending11 got=%0d exp=4", o_pend[11]); end
        checks++; if (o_err !== 64'hFE0) begin failures++; $display("FAIL full_err got=%h exp=%h", o_err, 64'hFE0); end
        checks++; if (o_drive !== 64'h0) begin failures++; $display("FAIL full_drive got=%h exp=0", o_drive); end
    endtask

    task automatic test_cwl_min();
        logic [63:0] exp_drive;
        logic [63:0] exp_done;
        logic [63:0] exp_err;
`ifdef PHY_WR_PREAMBLE_EN
        exp_drive = 64'h7F8;
        exp_done  = 64'h400;
        exp_err   = 64'hFFFFC;
`else
        exp_drive = 64'h3FC;
        exp_done  = 64'h200;
        exp_err   = 64'h0;
`endif
        do_reset();
        run(64'h1, 6'd0, 20);
        checks++; if (o_drive !== exp_drive) begin failures++; $display("FAIL cwlmin_drive got=%h exp=%h", o_drive, exp_drive); end
        checks++; if (o_done !== exp_done) begin failures++; $display("FAIL cwlmin_done got=%h exp=%h", o_done, exp_done); end
        checks++; if (o_err !== exp_err) begin failures++; $display("FAIL cwlmin_err got=%h exp=%h", o_err, exp_err); end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] exp_pre;
`ifdef PHY_WR_PREAMBLE_EN
        exp_pre = 64'h10;
`else
        exp_pre = 64'h0;
`endif
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk2x);
            wr_cmd_valid = (k == 0) || (k == 5);
            cwl_cycles   = (k == 0) ? 6'd10 : 6'd20;
        end
        checks++; if (drive_en !== 1'b1) begin failures++; $display("FAIL mid_drive_before got=%b exp=1", drive_en); end
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL mid_pending_before got=%0d exp=1", pending_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL mid_drive_async got=%b exp=0", drive_en); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL mid_pending_async got=%0d exp=0", pending_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_async got=%b exp=0", busy); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL mid_done_async got=%b exp=0", burst_done); end
        checks++; if (wr_cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_async got=%b exp=1", wr_cmd_ready); end
        @(negedge clk2x);
        rst = 1'b1;
        run(64'h1, 6'd5, 20);
        checks++; if (o_drive !== 64'h1FE0) begin failures++; $display("FAIL mid_after_drive got=%h exp=%h", o_drive, 64'h1FE0); end
        checks++; if (o_done !== 64'h1000) begin failures++; $display("FAIL mid_after_done got=%h exp=%h", o_done, 64'h1000); end
        checks++; if (o_err !== 64'h0) begin failures++; $display("FAIL mid_after_err got=%h exp=0", o_err); end
        checks++; if (o_pre !== exp_pre) begin failures++; $display("FAIL mid_after_preamble got=%h exp=%h", o_pre, exp_pre); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overlap();
        test_full();
        test_cwl_min();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phy_write_sequencer.md
PHY_WRITE_SEQUENCER -- requirements
Module: phy_write_sequencer

Interface
REQ-001 SHALL provide parameter BURST_LENGTH, default 8: clk2x beats per write burst, power of two.
REQ-002 SHALL provide parameter MAX_PENDING, default 4: outstanding WRITE commands awaiting their data window.
REQ-003 SHALL provide parameter CWL_WIDTH, default 6: width of the write-latency input.
REQ-004 SHALL provide port clk2x  input  1  beat clock; all logic on its rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port wr_cmd_valid  input  1  WRITE command issued to DRAM this cycle.
REQ-007 SHALL provide port wr_cmd_ready  output  1  a slot is free; combinational, equal to pending_cnt < MAX_PENDING.
REQ-008 SHALL provide port cwl_cycles  input  CWL_WIDTH  tCWL in clk2x cycles, sampled at command accept.
REQ-009 SHALL provide port drive_en  output  1  data-drive window; connects to the write datapath outflag.
REQ-010 SHALL provide port preamble  output  1  DQS preamble cycle (see Configuration).
REQ-011 SHALL provide port burst_done  output  1  one-cycle pulse on the last beat of each burst.
REQ-012 SHALL provide port pending_cnt  output  $clog2(MAX_PENDING)+1  accepted, not-yet-launched commands.
REQ-013 SHALL provide port busy  output  1  high when pending_cnt != 0 or the FSM is not IDLE.
REQ-014 SHALL provide port err_overlap  output  1  sticky flag: a burst launched late.

Function
REQ-015 A command SHALL be accepted when wr_cmd_valid && wr_cmd_ready; with valid && !ready it is dropped and err_overlap is set.
REQ-016 An accepted command SHALL load a FIFO-ordered slot with max(cwl_cycles,2); each loaded counter decrements every cycle, saturating at 0.
REQ-017 Launch SHALL be in issue order only; the head launches when its counter is 0 and the FSM is IDLE, or when the FSM is on the last BURST beat.
REQ-018 Latency: a command accepted at cycle T SHALL give drive_en high for cycles T+cwl .. T+cwl+BURST_LENGTH-1 when not delayed.
REQ-019 FSM states SHALL be IDLE, PRE and BURST. IDLE->PRE or IDLE->BURST on launch; PRE->BURST after one cycle; BURST holds a beat counter 0..BURST_LENGTH-1.
REQ-020 drive_en SHALL be high exactly in BURST; burst_done SHALL be high when beat == BURST_LENGTH-1.
REQ-021 Back-to-back: if the head is due on the last beat, BURST SHALL restart at beat 0 with no gap and no preamble.
REQ-022 If the head counter is 0 during BURST before the last beat, err_overlap SHALL set and the head SHALL launch at the next permitted point.
REQ-023 Simultaneous accept and launch SHALL leave pending_cnt unchanged; slot pointers wrap modulo MAX_PENDING.
REQ-024 err_overlap SHALL clear only on reset.

Reset
REQ-025 On rst low, the block SHALL asynchronously force FSM=IDLE, flush all slots, pending_cnt=0, drive_en=0, preamble=0, burst_done=0, busy=0 and err_overlap=0, including mid-burst.
REQ-026 wr_cmd_ready SHALL be 1 while in reset, and the first accept SHALL be possible on the first clk2x edge after reset release.

Configuration
REQ-027 Macro PHY_WR_PREAMBLE_EN defined: a launch from IDLE SHALL go through PRE, with preamble high when the head counter is 1, so the first beat timing is unchanged.
REQ-028 Macro PHY_WR_PREAMBLE_EN undefined: PRE SHALL be unreachable, preamble SHALL be tied 0, and launch from IDLE SHALL go directly to BURST.

Structure
REQ-029 The shared PHY package SHALL hold the FSM state enum (IDLE/PRE/BURST) and the default BURST_LENGTH constant.
REQ-030 The pending-slot queue SHALL be one sub-module, phy_wr_cwl_queue, with push, pop, head_due and head_due_next outputs.

Verification
REQ-031 Single command, cwl=10, accepted at T=0 -> drive_en high for cycles 10-17, burst_done at 17, busy low at 18.
REQ-032 Two commands at T=0 and T=8, cwl=10 -> drive_en continuous for cycles 10-25, burst_done at 17 and 25, err_overlap=0.
REQ-033 Two commands at T=0 and T=4, cwl=10 -> second burst at cycles 18-25, err_overlap=1.
REQ-034 Five commands with no launch in between, MAX_PENDING=4 -> wr_cmd_ready=0 after the fourth; the fifth is dropped and err_overlap=1.
REQ-035 rst asserted at beat 3 of a burst -> drive_en=0 immediately and pending_cnt=0; a new command after release times correctly.
REQ-036 With PHY_WR_PREAMBLE_EN, cwl=10, accept at T=0 -> preamble at cycle 9 only, drive_en at cycles 10-17.
